// File: rtl/shift_exec_stage.sv
// Execute-stage wrapper for SLL/SRL/SRA/PASS around a shared logical right shifter; 2-stage valid/ready pipe, result 1 edge after accept.
// Backpressure holds both stages (no loss/dup); FLUSH kills both stages, RST clears everything.
module shift_exec_stage #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       OPCODE,
    input  logic             USE_IMM,
    input  logic [31:0]      RS_DATA,
    input  logic [31:0]      RT_DATA,
    input  logic [4:0]       IMM_SHAMT,
    input  logic [4:0]       DEST,
    output logic [31:0]      SRL_IN,
    output logic [4:0]       SRL_SHAMT,
    input  logic [31:0]      SRL_OUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      RESULT,
    output logic [4:0]       OUT_DEST,
    output logic [CNT_W-1:0] OP_COUNT
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;

    logic             r_s1_vld;
    logic [1:0]       r_s1_op;
    logic [4:0]       r_s1_shamt;
    logic [31:0]      r_s1_opnd;
    logic [4:0]       r_s1_dest;
    logic             r_out_vld;
    logic [31:0]      r_result;
    logic [4:0]       r_out_dest;
    logic [CNT_W-1:0] r_op_count;

    logic             w_adv;
    logic             w_accept;
    logic             w_handoff;
    logic [4:0]       w_shamt_in;
    logic [31:0]      w_fill;
    logic [31:0]      w_result;
    logic             w_unused_rs;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    assign w_adv      = r_s1_vld & (~r_out_vld | OUT_READY);
    assign IN_READY   = ~r_s1_vld | w_adv;
    assign w_accept   = IN_VALID & IN_READY;
    assign w_handoff  = r_out_vld & OUT_READY;
    assign w_shamt_in = USE_IMM ? IMM_SHAMT : RS_DATA[4:0];
    assign w_unused_rs = ^RS_DATA[31:5];

    // Left shifts reuse the right shifter by reversing the operand on the way in and the result on the way out.
    assign SRL_IN    = (r_s1_op == OP_SLL) ? bitrev(r_s1_opnd) : r_s1_opnd;
    assign SRL_SHAMT = (r_s1_op == OP_SLL || r_s1_op == OP_SRL || r_s1_op == OP_SRA) ? r_s1_shamt : 5'd0;

    always_comb begin
        w_fill   = r_s1_opnd[31] ? ~(32'hFFFF_FFFF >> r_s1_shamt) : 32'd0;
        w_result = r_s1_opnd;
        case (r_s1_op)
            OP_SLL:  w_result = bitrev(SRL_OUT);
            OP_SRL:  w_result = SRL_OUT;
            OP_SRA:  w_result = SRL_OUT | w_fill;
            default: w_result = r_s1_opnd;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_vld   <= 1'b0;
            r_s1_op    <= 2'd0;
            r_s1_shamt <= 5'd0;
            r_s1_opnd  <= 32'd0;
            r_s1_dest  <= 5'd0;
            r_out_vld  <= 1'b0;
            r_result   <= 32'd0;
            r_out_dest <= 5'd0;
            r_op_count <= '0;
        end else if (FLUSH) begin
            r_s1_vld  <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_vld   <= 1'b1;
                r_s1_op    <= OPCODE;
                r_s1_shamt <= w_shamt_in;
                r_s1_opnd  <= RT_DATA;
                r_s1_dest  <= DEST;
            end else if (w_adv) begin
                r_s1_vld <= 1'b0;
            end
            if (w_adv) begin
                r_out_vld  <= 1'b1;
                r_result   <= w_result;
                r_out_dest <= r_s1_dest;
            end else if (OUT_READY) begin
                r_out_vld <= 1'b0;
            end
            if (w_handoff) begin
                r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign OUT_VALID = r_out_vld;
    assign RESULT    = r_result;
    assign OUT_DEST  = r_out_dest;
    assign OP_COUNT  = r_op_count;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: table vectors plus scoreboarded backpressure, flush, reset and counter-wrap sequences.
module tb_shift_exec_stage;

    logic        CLK;
    logic        RST;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  OPCODE;
    logic        USE_IMM;
    logic [31:0] RS_DATA;
    logic [31:0] RT_DATA;
    logic [4:0]  IMM_SHAMT;
    logic [4:0]  DEST;
    logic [31:0] SRL_IN;
    logic [4:0]  SRL_SHAMT;
    logic [31:0] SRL_OUT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic [4:0]  OUT_DEST;
    logic [15:0] OP_COUNT;

    shift_exec_stage #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OPCODE(OPCODE), .USE_IMM(USE_IMM), .RS_DATA(RS_DATA), .RT_DATA(RT_DATA),
        .IMM_SHAMT(IMM_SHAMT), .DEST(DEST),
        .SRL_IN(SRL_IN), .SRL_SHAMT(SRL_SHAMT), .SRL_OUT(SRL_OUT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RESULT(RESULT), .OUT_DEST(OUT_DEST), .OP_COUNT(OP_COUNT)
    );

    // Stand-in for the shared logical right shifter.
    assign SRL_OUT = SRL_IN >> SRL_SHAMT;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic        use_imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  imm;
        logic [4:0]  dest;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dest;
    } exp_t;

    vec_t        tbl[12];
    exp_t        q[$];
    int          n_cmp;
    int          n_err;
    logic [15:0] exp_cnt;
    logic [31:0] drv_exp;
    logic        last_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=%h required=none", name, act);
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] rt);
        case (op)
            2'b00:   return rt << sh;
            2'b01:   return rt >> sh;
            2'b10:   return 32'($signed(rt) >>> sh);
            default: return rt;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        IN_VALID  = 1'b1;
        OPCODE    = v.op;
        USE_IMM   = v.use_imm;
        RS_DATA   = v.rs;
        RT_DATA   = v.rt;
        IMM_SHAMT = v.imm;
        DEST      = v.dest;
        drv_exp   = v.exp;
    endtask

    // One clock: scoreboard bookkeeping at the falling edge, return 1ns after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge CLK);
        check("op_count", 32'(OP_COUNT), 32'(exp_cnt));
        last_acc = 1'b0;
        if (RST) begin
            q.delete();
            exp_cnt = '0;
        end else if (FLUSH) begin
            q.delete();
        end else begin
            if (OUT_VALID && OUT_READY) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_output", RESULT);
                end else begin
                    e = q.pop_front();
                    check("result", RESULT, e.res);
                    check("out_dest", 32'(OUT_DEST), 32'(e.dest));
                end
                exp_cnt++;
            end
            if (IN_VALID && IN_READY) begin
                q.push_back('{res: drv_exp, dest: DEST});
                last_acc = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string name);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        vec_t        v;
        logic [15:0] base;
        logic [4:0]  sh;
        int          idx;
        int          cyc;
        int          n;

        n_cmp = 0; n_err = 0; exp_cnt = '0; drv_exp = '0; last_acc = 1'b0;
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        OPCODE = 2'd0; USE_IMM = 1'b0; RS_DATA = '0; RT_DATA = '0; IMM_SHAMT = '0; DEST = '0;

        //                op     imm   rs              rt              imm    dest   expected
        tbl[0]  = '{2'd1, 1'b1, 32'h0000_0000, 32'h8000_00F0, 5'd4,  5'd1,  32'h0800_000F};
        tbl[1]  = '{2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  5'd2,  32'h8000_0000};
        tbl[2]  = '{2'd2, 1'b1, 32'h0000_0000, 32'hF000_0000, 5'd4,  5'd3,  32'hFF00_0000};
        tbl[3]  = '{2'd2, 1'b1, 32'h0000_0000, 32'h7000_0000, 5'd4,  5'd4,  32'h0700_0000};
        tbl[4]  = '{2'd2, 1'b1, 32'h0000_001F, 32'h8000_0001, 5'd0,  5'd5,  32'h8000_0001};
        tbl[5]  = '{2'd0, 1'b1, 32'h0000_0000, 32'h8000_0001, 5'd0,  5'd6,  32'h8000_0001};
        tbl[6]  = '{2'd1, 1'b0, 32'h0000_0025, 32'hFFFF_FFFF, 5'd9,  5'd7,  32'h07FF_FFFF};
        tbl[7]  = '{2'd3, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 5'd31, 5'd8,  32'hDEAD_BEEF};
        tbl[8]  = '{2'd2, 1'b0, 32'h0000_001F, 32'h8000_0000, 5'd0,  5'd9,  32'hFFFF_FFFF};
        tbl[9]  = '{2'd0, 1'b1, 32'h0000_0000, 32'h1234_5678, 5'd8,  5'd10, 32'h3456_7800};
        tbl[10] = '{2'd1, 1'b1, 32'h0000_0000, 32'h8000_0000, 5'd31, 5'd11, 32'h0000_0001};
        tbl[11] = '{2'd2, 1'b1, 32'h0000_0000, 32'h8765_4321, 5'd16, 5'd31, 32'hFFFF_8765};

        @(posedge CLK); #1;
        step();
        RST = 1'b0;
        #1;
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_result", RESULT, 32'd0);
        check("rst_out_dest", 32'(OUT_DEST), 32'd0);
        check("rst_op_count", 32'(OP_COUNT), 32'd0);
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_srl_in", SRL_IN, 32'd0);

        // Single-issue table: latency, shifter operands and result.
        for (int i = 0; i < 12; i++) begin
            OUT_READY = 1'b1;
            drive(tbl[i]);
            step();
            check("tbl_accept", 32'(last_acc), 32'd1);
            IN_VALID = 1'b0;
            #1;
            check("tbl_lat_n", 32'(OUT_VALID), 32'd0);
            check("tbl_srl_in", SRL_IN, (tbl[i].op == 2'd0) ? {<<{tbl[i].rt}} : tbl[i].rt);
            sh = tbl[i].use_imm ? tbl[i].imm : tbl[i].rs[4:0];
            check("tbl_srl_shamt", 32'(SRL_SHAMT), (tbl[i].op == 2'd3) ? 32'd0 : 32'(sh));
            step();
            check("tbl_lat_n1", 32'(OUT_VALID), 32'd1);
            step();
        end
        drain("tbl_drained");

        // Back-to-back with OUT_READY low for three cycles.
        base = exp_cnt;
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 40) begin
            drive(tbl[idx]);
            OUT_READY = (cyc >= 3);
            #1;
            if (cyc == 2) begin
                check("bp_in_ready", 32'(IN_READY), 32'd0);
                check("bp_result_hold", RESULT, tbl[0].exp);
            end
            if (cyc == 3) check("bp_result_hold2", RESULT, tbl[0].exp);
            step();
            if (last_acc) idx++;
            cyc++;
        end
        check("bp_all_accepted", 32'(idx), 32'd4);
        drain("bp_drained");
        check("bp_count", 32'(OP_COUNT), 32'(base + 16'd4));

        // Flush with both stages full and a new instruction offered.
        OUT_READY = 1'b0;
        drive(tbl[4]); step();
        drive(tbl[5]); step();
        check("fl_out_valid_pre", 32'(OUT_VALID), 32'd1);
        base = exp_cnt;
        drive(tbl[6]);
        FLUSH = 1'b1; OUT_READY = 1'b1;
        step();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        #1;
        check("fl_out_valid", 32'(OUT_VALID), 32'd0);
        check("fl_count", 32'(OP_COUNT), 32'(base));
        step();
        check("fl_no_capture", 32'(OUT_VALID), 32'd0);
        drain("fl_drained");

        // Randomised stream with random backpressure and bubbles.
        for (int k = 0; k < 40; k++) begin
            v.op = 2'($urandom_range(0, 3));
            v.use_imm = 1'($urandom_range(0, 1));
            v.rs = $urandom; v.rt = $urandom;
            v.imm = 5'($urandom_range(0, 31));
            v.dest = 5'($urandom_range(0, 31));
            v.exp = model(v.op, v.use_imm ? v.imm : v.rs[4:0], v.rt);
            drive(v);
            cyc = 0;
            do begin
                OUT_READY = 1'($urandom_range(0, 1));
                step();
                cyc++;
            end while (!last_acc && cyc < 100);
            if (!last_acc) fail_now("rand_accept_timeout", 32'(cyc));
            if ($urandom_range(0, 3) == 0) begin
                IN_VALID = 1'b0;
                step();
            end
        end
        drain("rand_drained");

        // Reset mid-stream with FLUSH also high.
        OUT_READY = 1'b0;
        drive(tbl[7]); step();
        drive(tbl[8]); step();
        drive(tbl[9]);
        check("rs_out_valid_pre", 32'(OUT_VALID), 32'd1);
        RST = 1'b1; FLUSH = 1'b1;
        step();
        RST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0;
        #1;
        check("rs_out_valid", 32'(OUT_VALID), 32'd0);
        check("rs_result", RESULT, 32'd0);
        check("rs_out_dest", 32'(OUT_DEST), 32'd0);
        check("rs_op_count", 32'(OP_COUNT), 32'd0);
        check("rs_in_ready", 32'(IN_READY), 32'd1);
        check("rs_srl_shamt", 32'(SRL_SHAMT), 32'd0);

        // Stream PASS ops until the counter reaches 0xFFFF, then one handoff wraps it.
        OUT_READY = 1'b1;
        n = 0;
        while (exp_cnt != 16'hFFFF && n < 70000) begin
            v = '{2'd3, 1'b1, 32'd0, 32'(n), 5'(n), 5'(n), 32'(n)};
            drive(v);
            step();
            n++;
        end
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        #1;
        check("wrap_pre", 32'(OP_COUNT), 32'h0000_FFFF);
        OUT_READY = 1'b1;
        step();
        check("wrap", 32'(OP_COUNT), 32'd0);
        drain("wrap_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Execute-stage wrapper around the shared 32-bit logical right shifter; owns operand selection, pipelining and handshaking for all shift instructions.
- Issues operand and shift amount to the shifter, takes its combinational result back, and turns it into SLL / SRL / SRA results using bit reversal and sign-fill masking.
- Sits between decode/register-read and writeback. Two-stage valid/ready pipeline with backpressure and flush.

Parameters:
- CNT_W, 16, width of completed-operation counter OP_COUNT.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- FLUSH  input  1  synchronous pipeline kill (branch redirect).
- IN_VALID  input  1  upstream instruction valid.
- IN_READY  output  1  stage can accept the instruction.
- OPCODE  input  2  00 SLL, 01 SRL, 10 SRA, 11 PASS (result = operand).
- USE_IMM  input  1  1: shamt = IMM_SHAMT; 0: shamt = RS_DATA[4:0].
- RS_DATA  input  32  register shift-amount source.
- RT_DATA  input  32  value to be shifted.
- IMM_SHAMT  input  5  immediate shift amount.
- DEST  input  5  destination register tag, carried through.
- SRL_IN  output  32  operand to shifter IN.
- SRL_SHAMT  output  5  amount to shifter SHAMT.
- SRL_OUT  input  32  shifter result (combinational from SRL_IN/SRL_SHAMT).
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- RESULT  output  32  shift result.
- OUT_DEST  output  5  destination tag for RESULT.
- OP_COUNT  output  CNT_W  number of results handed off (OUT_VALID & OUT_READY).

Behaviour:
- Reset (RST=1 at edge): S1_VALID=0, OUT_VALID=0, RESULT=0, OUT_DEST=0, OP_COUNT=0, all operand registers 0. RST has priority over FLUSH and all handshakes.
- Stage 1 (operand register): captures OPCODE, selected shamt, RT_DATA and DEST when IN_VALID & IN_READY.
- Stage 1 to shifter: SRL_SHAMT = registered shamt.
  - SRL_IN = bit-reverse(operand) for SLL; operand otherwise.
  - For PASS, SRL_SHAMT is forced to 0.
- Stage 2 (result register): computes the result from SRL_OUT in the same cycle as stage 1 holds it.
  - SLL: bit-reverse(SRL_OUT).
  - SRL: SRL_OUT.
  - SRA: SRL_OUT | fill, where fill = top shamt bits set if operand[31]=1, else 0. Fill is generated internally, not through the shifter.
  - PASS: operand.
- Advance rule: stage 2 loads when S1_VALID & (!OUT_VALID | OUT_READY).
  - IN_READY = !S1_VALID | that same advance condition. Combinational, with no dependence on IN_VALID.
- Latency: an instruction accepted at edge N has OUT_VALID=1 after edge N+1.
  - Throughput is 1 per cycle with OUT_READY held at 1.
- Backpressure: when OUT_VALID=1 and OUT_READY=0:
  - RESULT and OUT_DEST hold.
  - Stage 1 holds its contents.
  - IN_READY=0 if S1_VALID=1.
  - No data is lost or duplicated.
- Simultaneous events:
  - Handoff and new stage-2 load in the same cycle is legal: OUT_VALID stays 1 with new data.
  - Stage 1 may drain and refill in the same cycle.
- FLUSH=1 at edge: S1_VALID=0, OUT_VALID=0.
  - Input is not captured that cycle, even if IN_VALID=1. IN_READY may still read 1; the upstream side treats FLUSH as a kill.
  - OP_COUNT is not incremented for the flushed result, even if OUT_READY=1.
  - RESULT/OUT_DEST data values are don't-care after a flush.
- OP_COUNT increments on every OUT_VALID & OUT_READY edge without FLUSH and wraps modulo 2^CNT_W.
- Shamt width: only the low 5 bits of RS_DATA are used. Shamt 0 gives the operand unchanged for every opcode.

Test Plan:
- Reset, then SRL with RT=0x8000_00F0, IMM 4, USE_IMM=1, OUT_READY=1 -> after 2 edges OUT_VALID=1, RESULT=0x0800_000F, OP_COUNT=1 one edge later.
- SLL with RT=0x0000_0001, RS=0xFFFF_FFFF (shamt 31), USE_IMM=0 -> RESULT=0x8000_0000; SRL_IN observed = 0x8000_0000.
- SRA with RT=0xF000_0000, shamt 4 -> 0xFF00_0000. RT=0x7000_0000, shamt 4 -> 0x0700_0000. Shamt 0 on 0x8000_0001 -> 0x8000_0001.
- Back-to-back 4 ops with OUT_READY held 0 for 3 cycles:
  - After 2 accepts, IN_READY=0 and RESULT stable.
  - Releasing OUT_READY drains in order with no loss or duplicates.
  - OP_COUNT=4 at end.
- FLUSH asserted with both stages valid and IN_VALID=1 -> next cycle OUT_VALID=0, no new capture, OP_COUNT unchanged.
- RST asserted mid-stream with OUT_VALID=1 and FLUSH=1 -> all outputs at reset values after the edge. Preset OP_COUNT=0xFFFF then one handoff -> wraps to 0x0000.
